// File: rtl/header_insert_scheduler.sv
// header_insert_scheduler: round-robin owner of the inserter header port.
// One header per output packet; next grant waits for the packet's EOP.
module header_insert_scheduler #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_SRC      = 4,
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              req_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      req_header,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
    output logic [NUM_SRC-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              header_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    input  logic                            ready_insert,
    input  logic                            valid_out,
    input  logic                            ready_out,
    input  logic                            last_out,
    output logic [SRC_WD-1:0]               grant_id,
    output logic                            busy,
    output logic                            err_keep,
    output logic [15:0]                     hdr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_WAIT_EOP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SRC_WD-1:0]       r_rr_ptr;
    logic [SRC_WD-1:0]       r_grant_id;
    logic [DATA_WD-1:0]      r_header;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic                    r_err_keep;
    logic [15:0]             r_hdr_cnt;

    logic [SRC_WD-1:0]       w_winner;
    logic                    w_found;
    logic                    w_grant;
    logic                    w_keep_zero;
    logic                    w_hs_insert;
    logic                    w_eop;
    logic [DATA_WD-1:0]      w_win_header;
    logic [DATA_BYTE_WD-1:0] w_win_keep;

    function automatic logic [SRC_WD-1:0] f_inc(input logic [SRC_WD-1:0] v);
        return (int'(v) == NUM_SRC - 1) ? '0 : v + 1'b1;
    endfunction

    // Round-robin search: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
                w_found  = 1'b1;
                w_winner = SRC_WD'((int'(r_rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    assign w_win_header = req_header[w_winner*DATA_WD +: DATA_WD];
    assign w_win_keep   = req_keep[w_winner*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign w_keep_zero  = (w_win_keep == '0);
    assign w_grant      = (r_state == S_IDLE) && w_found && !rst;
    assign w_hs_insert  = (r_state == S_OFFER) && ready_insert;
    assign w_eop        = valid_out && ready_out && last_out;

    assign req_ready     = w_grant ? (NUM_SRC'(1) << w_winner) : '0;
    assign valid_insert  = (r_state == S_OFFER);
    assign header_insert = r_header;
    assign keep_insert   = r_keep;
    assign grant_id      = r_grant_id;
    assign busy          = (r_state != S_IDLE);
    assign err_keep      = r_err_keep;
    assign hdr_cnt       = r_hdr_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: EOP only counts while a granted packet is in flight.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (w_grant && !w_keep_zero) w_state_nxt = S_OFFER;
            S_OFFER:    if (ready_insert) w_state_nxt = S_WAIT_EOP;
            S_WAIT_EOP: if (w_eop) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Header latch, pointer advance, drop flag and accepted-header count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_header   <= '0;
            r_keep     <= '0;
            r_err_keep <= 1'b0;
            r_hdr_cnt  <= '0;
        end else begin
            r_err_keep <= 1'b0;
            if (w_grant) begin
                r_header   <= w_win_header;
                r_keep     <= w_win_keep;
                r_grant_id <= w_winner;
                r_err_keep <= w_keep_zero;
                if (w_keep_zero) r_rr_ptr <= f_inc(w_winner);
            end
            if (w_hs_insert) begin
                r_hdr_cnt <= r_hdr_cnt + 16'd1;
                r_rr_ptr  <= f_inc(r_grant_id);
            end
        end
    end

endmodule

// File: tb/tb_header_insert_scheduler.sv
// tb_header_insert_scheduler: directed vectors for the header scheduler.
// Inputs change 2ns after a rising edge; outputs are checked 1ns later.
module tb_header_insert_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_header;
    logic [15:0]  req_keep;
    logic [3:0]   req_ready;
    logic         valid_insert;
    logic [31:0]  header_insert;
    logic [3:0]   keep_insert;
    logic         ready_insert;
    logic         valid_out;
    logic         ready_out;
    logic         last_out;
    logic [1:0]   grant_id;
    logic         busy;
    logic         err_keep;
    logic [15:0]  hdr_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] exp_rdy;

    header_insert_scheduler #(
        .DATA_WD(32),
        .NUM_SRC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_header(req_header),
        .req_keep(req_keep),
        .req_ready(req_ready),
        .valid_insert(valid_insert),
        .header_insert(header_insert),
        .keep_insert(keep_insert),
        .ready_insert(ready_insert),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .last_out(last_out),
        .grant_id(grant_id),
        .busy(busy),
        .err_keep(err_keep),
        .hdr_cnt(hdr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int i, input logic [31:0] h,
                           input logic [3:0] k);
        req_header[i*32 +: 32] = h;
        req_keep[i*4 +: 4]     = k;
    endtask

    task automatic eop_cycle();
        valid_out = 1'b1;
        ready_out = 1'b1;
        last_out  = 1'b1;
        step();
        valid_out = 1'b0;
        ready_out = 1'b0;
        last_out  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_header   = '0;
        req_keep     = '0;
        ready_insert = 1'b0;
        valid_out    = 1'b0;
        ready_out    = 1'b0;
        last_out     = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_insert), 32'd0);
        chk("rst_header", header_insert, 32'd0);
        chk("rst_keep", 32'(keep_insert), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_keep), 32'd0);
        chk("rst_cnt", 32'(hdr_cnt), 32'd0);

        // single source
        set_src(2, 32'hA5A5_0001, 4'b0111);
        req_valid    = 4'b0100;
        ready_insert = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        #1;
        chk("t1_valid", 32'(valid_insert), 32'd1);
        chk("t1_header", header_insert, 32'hA5A5_0001);
        chk("t1_keep", 32'(keep_insert), 32'h7);
        chk("t1_gid", 32'(grant_id), 32'd2);
        chk("t1_no_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("t1_valid_drop", 32'(valid_insert), 32'd0);
        chk("t1_cnt", 32'(hdr_cnt), 32'd1);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        repeat (3) step();
        chk("t1_busy_hold", 32'(busy), 32'd1);
        eop_cycle();
        #1;
        chk("t1_busy_done", 32'(busy), 32'd0);

        // round-robin over 8 packets
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 32'h1000_0000 + i, 4'hF);
        req_valid    = 4'hF;
        ready_insert = 1'b1;
        #1;
        for (int p = 0; p < 8; p++) begin
            exp_rdy = 4'b0001 << (p % 4);
            chk("rr_grant", 32'(req_ready), 32'(exp_rdy));
            step();
            #1;
            chk("rr_gid", 32'(grant_id), 32'(p % 4));
            chk("rr_header", header_insert, 32'h1000_0000 + (p % 4));
            step();
            valid_out = 1'b1;
            ready_out = 1'b1;
            last_out  = 1'b1;
            #1;
            chk("rr_bubble", 32'(req_ready), 32'd0);
            step();
            valid_out = 1'b0;
            ready_out = 1'b0;
            last_out  = 1'b0;
            #1;
        end
        req_valid = '0;
        #1;
        chk("rr_cnt", 32'(hdr_cnt), 32'd8);

        // backpressure on the insert port
        set_src(0, 32'hBEEF_0000, 4'b0011);
        req_valid    = 4'b0001;
        ready_insert = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'h1);
        step();
        for (int i = 0; i < 6; i++) begin
            set_src(0, 32'hDEAD_0000 + i, 4'hF);
            #1;
            chk("bp_header", header_insert, 32'hBEEF_0000);
            chk("bp_keep", 32'(keep_insert), 32'h3);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(valid_insert), 32'd1);
            step();
        end
        ready_insert = 1'b1;
        #1;
        chk("bp_valid_hs", 32'(valid_insert), 32'd1);
        step();
        req_valid = '0;
        #1;
        chk("bp_valid_drop", 32'(valid_insert), 32'd0);
        chk("bp_cnt", 32'(hdr_cnt), 32'd9);

        // last_out without ready_out is not an EOP
        valid_out = 1'b1;
        last_out  = 1'b1;
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("eq_hold", 32'(busy), 32'd1);
        end
        ready_out = 1'b1;
        #1;
        chk("eq_hs_cycle", 32'(busy), 32'd1);
        step();
        valid_out = 1'b0;
        ready_out = 1'b0;
        last_out  = 1'b0;
        #1;
        chk("eq_idle", 32'(busy), 32'd0);

        // zero keep from source 1, source 3 waiting
        set_src(1, 32'h0BAD_0001, 4'b0000);
        set_src(3, 32'h3333_0003, 4'hF);
        req_valid    = 4'b1010;
        ready_insert = 1'b1;
        #1;
        chk("zk_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1000;
        #1;
        chk("zk_err", 32'(err_keep), 32'd1);
        chk("zk_valid", 32'(valid_insert), 32'd0);
        chk("zk_busy", 32'(busy), 32'd0);
        chk("zk_ready3", 32'(req_ready), 32'h8);
        chk("zk_cnt", 32'(hdr_cnt), 32'd9);
        step();
        req_valid = '0;
        #1;
        chk("zk_err_clr", 32'(err_keep), 32'd0);
        chk("zk_gid", 32'(grant_id), 32'd3);
        chk("zk_header", header_insert, 32'h3333_0003);
        step();
        #1;
        chk("zk_cnt_inc", 32'(hdr_cnt), 32'd10);
        eop_cycle();
        #1;
        chk("zk_idle", 32'(busy), 32'd0);

        // EOP handshake during OFFER is ignored
        set_src(1, 32'h1111_0001, 4'b1000);
        req_valid    = 4'b0010;
        ready_insert = 1'b0;
        #1;
        chk("eo_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        valid_out = 1'b1;
        ready_out = 1'b1;
        last_out  = 1'b1;
        step();
        valid_out = 1'b0;
        ready_out = 1'b0;
        last_out  = 1'b0;
        #1;
        chk("eo_still_offer", 32'(valid_insert), 32'd1);
        ready_insert = 1'b1;
        step();
        #1;
        chk("eo_wait", 32'(busy), 32'd1);
        chk("eo_cnt", 32'(hdr_cnt), 32'd11);
        step();
        #1;
        chk("eo_wait_hold", 32'(busy), 32'd1);
        eop_cycle();
        #1;
        chk("eo_idle", 32'(busy), 32'd0);

        // reset during WAIT_EOP after 3 accepted headers
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 32'h2000_0000 + i, 4'hF);
        req_valid    = 4'b0111;
        ready_insert = 1'b1;
        for (int p = 0; p < 3; p++) begin
            #1;
            exp_rdy = 4'b0001 << p;
            chk("mr_grant", 32'(req_ready), 32'(exp_rdy));
            step();
            step();
            if (p < 2) eop_cycle();
        end
        #1;
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_cnt", 32'(hdr_cnt), 32'd3);
        req_valid = 4'b1100;
        rst       = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("mr_valid", 32'(valid_insert), 32'd0);
        chk("mr_busy0", 32'(busy), 32'd0);
        chk("mr_cnt0", 32'(hdr_cnt), 32'd0);
        chk("mr_gid0", 32'(grant_id), 32'd0);
        chk("mr_header0", header_insert, 32'd0);
        chk("mr_keep0", 32'(keep_insert), 32'd0);
        chk("mr_err0", 32'(err_keep), 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_first", 32'(req_ready), 32'h4);
        req_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/header_insert_scheduler.md
# header_insert_scheduler

Shares the single header-insert port of `axi_stream_insert_header` among `NUM_SRC` header requesters. Grants are round-robin, with exactly one header per output packet. Each accepted header is presented on `valid_insert`/`header_insert`/`keep_insert`. The scheduler then tracks the output stream and holds off the next grant until the packet's `last_out` beat has been handshaken. It sits between the per-channel header generators and the inserter, alongside the inserter's output stream.

## Interface
- `DATA_WD`, 32, data/header width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, byte-enable width
- `NUM_SRC`, 4, number of header requesters (2..8)
- `SRC_WD`, `$clog2(NUM_SRC)`, width of the grant index

Ports:
- `clk`  in  1  sole clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  `NUM_SRC`  per-source header request
- `req_header`  in  `NUM_SRC*DATA_WD`  per-source header; source i occupies bits [i*DATA_WD +: DATA_WD]
- `req_keep`  in  `NUM_SRC*DATA_BYTE_WD`  per-source header keep, same packing
- `req_ready`  out  `NUM_SRC`  one-hot pulse; source i's header is taken on this cycle
- `valid_insert`  out  1  header valid to the inserter
- `header_insert`  out  `DATA_WD`  latched header
- `keep_insert`  out  `DATA_BYTE_WD`  latched keep
- `ready_insert`  in  1  inserter accepts the header
- `valid_out`, `ready_out`, `last_out`  in  1 each  monitor taps of the inserter output handshake
- `grant_id`  out  `SRC_WD`  source owning the current packet
- `busy`  out  1  high in OFFER or WAIT_EOP
- `err_keep`  out  1  one-cycle pulse when an all-zero keep is rejected
- `hdr_cnt`  out  16  count of headers accepted by the inserter; wraps 0xFFFF→0

## Operation

**States:** IDLE, OFFER, WAIT_EOP.

**IDLE**
- The winner is the first set `req_valid` bit searching upward from `rr_ptr`, with wrap.
- `req_ready[winner]` is driven combinationally in the same cycle. It is only asserted in IDLE, and only when `rst` is low.
- On that edge, the winner's header and keep are latched and `grant_id` is set to the winner.
- If the latched keep is nonzero, the next state is OFFER.
- If the keep is 4'b0000, the header is consumed but dropped: `err_keep` pulses, the state stays IDLE, and `rr_ptr` still advances.

**OFFER**
- `valid_insert` = 1. Header and keep are held stable until `valid_insert && ready_insert`.
- On that handshake:
  - `hdr_cnt` increments.
  - `rr_ptr` becomes `grant_id+1`, modulo `NUM_SRC`.
  - The next state is WAIT_EOP.
  - `valid_insert` drops the following cycle.

**WAIT_EOP**
- On `valid_out && ready_out && last_out`, the next state is IDLE.
- Beats with `last_out` = 1 that are not handshaken are ignored.

**Other rules**
- An EOP handshake seen in IDLE or OFFER belongs to no granted packet and is ignored.
- `busy` = (state != IDLE).
- `grant_id` holds its last value while in IDLE.
- `req_ready` is never asserted for a source whose `req_valid` is low.
- At most one `req_ready` bit is high in any cycle.

## Timing

**Reset**
- Values after reset: state IDLE, `rr_ptr` 0, `valid_insert` 0, `header_insert` 0, `keep_insert` 0, `req_ready` 0, `grant_id` 0, `err_keep` 0, `hdr_cnt` 0.
- Reset asserted mid-OFFER or mid-WAIT_EOP abandons the packet. `valid_insert` is 0 in the cycle after the reset edge.

**Latency**
- A request sampled in IDLE at edge N (`req_ready` high in cycle N) gives `valid_insert` high from cycle N+1.
- With `ready_insert` high, the header handshake occurs in cycle N+1.

**Packet turnaround**
- An EOP handshake at cycle M returns the FSM to IDLE at M+1.
- The earliest next `req_ready` is therefore in cycle M+1: a minimum one-cycle IDLE bubble between packets.

**Other timing rules**
- `req_valid` may drop while not granted, with no effect. Requests are not required to be sticky.
- An `err_keep` drop costs one cycle. The next arbitration happens in the following IDLE cycle.
- `hdr_cnt` is updated one cycle after the insert handshake and is visible on the same edge as the transition to WAIT_EOP.

## Test plan
- **Single source:** source 2 requests with header 0xA5A5_0001 and keep 4'b0111; `ready_insert` = 1; an EOP arrives 5 cycles later.
  - `req_ready` = 4'b0100 for one cycle.
  - `valid_insert` is high exactly one cycle with 0xA5A5_0001 / 4'b0111.
  - `busy` returns to 0 one cycle after the EOP.
  - `hdr_cnt` = 1.
- **Round-robin:** all 4 sources request continuously for 8 packets.
  - Grant order is 0,1,2,3,0,1,2,3.
  - No grant occurs before the previous EOP handshake + 1 cycle.
- **Backpressure:** `ready_insert` is held low 6 cycles in OFFER while `req_header[0]` changes.
  - `header_insert` and `keep_insert` stay constant.
  - No second `req_ready` pulse occurs.
  - The handshake completes on the cycle `ready_insert` rises.
- **EOP qualification:** `last_out` = 1 with `ready_out` = 0 for 3 cycles, then `ready_out` = 1.
  - The FSM stays in WAIT_EOP until the handshake cycle.
  - An EOP injected during OFFER is ignored.
- **Zero keep:** source 1 offers keep 4'b0000 while source 3 also requests.
  - `err_keep` pulses once and `valid_insert` stays 0.
  - The next cycle grants source 3.
  - `hdr_cnt` is unchanged.
- **Reset mid-packet:** assert `rst` during WAIT_EOP after 3 accepted headers.
  - All outputs are 0 next cycle and `hdr_cnt` = 0.
  - The first post-reset grant goes to the lowest requesting index.
